// File: rtl/stage4_mem.sv
// Memory-access pipeline stage: registers the execute bus, captures the SRAM read
// word across write-back stalls, and aligns/extends load data for write-back.
module stage4_mem #(
  localparam int unsigned ES_TO_MS_W = 78,
  localparam int unsigned MS_TO_WS_W = 70,
  localparam int unsigned MS_TO_DS_W = 39
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  es_to_ms_valid,
  output logic                  ms_allow_in,
  input  logic [ES_TO_MS_W-1:0] es_to_ms_bus,
  input  logic [31:0]           data_sram_rdata,
  input  logic                  ws_allow_in,
  output logic                  ms_to_ws_valid,
  output logic [MS_TO_WS_W-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_W-1:0] ms_to_ds_bus
);

  logic                  ms_valid;
  logic                  rdata_held;
  logic [ES_TO_MS_W-1:0] bus_r;
  logic [31:0]           rdata_buf;
  logic                  ms_ready_go;

  logic [31:0] pc;
  logic        gr_we;
  logic        res_from_mem;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [1:0]  offset;
  logic [4:0]  ld_op;

  logic [31:0] lw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [31:0] final_result;

  assign pc           = bus_r[31:0];
  assign gr_we        = bus_r[32];
  assign res_from_mem = bus_r[33];
  assign dest         = bus_r[38:34];
  assign alu_result   = bus_r[70:39];
  assign offset       = bus_r[72:71];
  assign ld_op        = bus_r[77:73];

  assign ms_ready_go    = 1'b1;
  assign ms_allow_in    = !ms_valid || (ms_ready_go && ws_allow_in);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  // Pipeline register; the SRAM word is only live in the first cycle, so a stall captures it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_valid   <= 1'b0;
      bus_r      <= '0;
      rdata_buf  <= '0;
      rdata_held <= 1'b0;
    end else if (ms_allow_in) begin
      ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid) begin
        bus_r      <= es_to_ms_bus;
        rdata_held <= 1'b0;
      end
    end else if (ms_valid && !rdata_held) begin
      rdata_buf  <= data_sram_rdata;
      rdata_held <= 1'b1;
    end
  end

  // Load alignment and extension; an empty ld_op falls back to a full word.
  always_comb begin
    lw       = rdata_held ? rdata_buf : data_sram_rdata;
    ld_byte  = 8'(lw >> {offset, 3'b000});
    ld_half  = offset[1] ? lw[31:16] : lw[15:0];
    load_val = lw;
    if (ld_op[1])      load_val = {{24{ld_byte[7]}}, ld_byte};
    else if (ld_op[2]) load_val = {24'b0, ld_byte};
    else if (ld_op[3]) load_val = {{16{ld_half[15]}}, ld_half};
    else if (ld_op[4]) load_val = {16'b0, ld_half};
    final_result = res_from_mem ? load_val : alu_result;
  end

  assign ms_to_ws_bus = {final_result, dest, gr_we, pc};
  assign ms_to_ds_bus = {ms_valid, gr_we && ms_valid, dest, final_result};

endmodule

// File: tb/tb_stage4_mem.sv
// Directed scoreboard bench for stage4_mem: loads, stalls, bubbles and reset.
module tb_stage4_mem;

  logic        clk;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allow_in;
  logic [77:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic        ws_allow_in;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_bus;

  int unsigned n_eval;
  int unsigned n_fail;
  logic [69:0] sb[$];

  stage4_mem dut (
    .clk            (clk),
    .reset          (reset),
    .es_to_ms_valid (es_to_ms_valid),
    .ms_allow_in    (ms_allow_in),
    .es_to_ms_bus   (es_to_ms_bus),
    .data_sram_rdata(data_sram_rdata),
    .ws_allow_in    (ws_allow_in),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .ms_to_ds_bus   (ms_to_ds_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [77:0] mk_bus(input logic [31:0] pc, input logic we, input logic rfm,
                                         input logic [4:0] dst, input logic [31:0] res,
                                         input logic [1:0] off, input logic [4:0] op);
    return {op, off, res, dst, rfm, we, pc};
  endfunction

  function automatic logic [31:0] ld_model(input logic [4:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = (off >= 2'd2) ? w[31:16] : w[15:0];
    case (op)
      5'b00010: return {{24{b[7]}}, b};
      5'b00100: return {24'h0, b};
      5'b01000: return {{16{h[15]}}, h};
      5'b10000: return {16'h0, h};
      default:  return w;
    endcase
  endfunction

  function automatic logic [69:0] exp_ws(input logic [77:0] b, input logic [31:0] rd);
    logic [31:0] fr;
    fr = b[33] ? ld_model(b[77:73], b[72:71], rd) : b[70:39];
    return {fr, b[38:34], b[32], b[31:0]};
  endfunction

  // One cycle: offer v/b, supply rdata for the instruction now in the stage, check outputs.
  task automatic cyc(input logic v, input logic [77:0] b, input logic [31:0] rd,
                     input logic wa, input logic [69:0] exp_new);
    logic        exp_v;
    logic [69:0] head;
    @(negedge clk);
    es_to_ms_valid  = v;
    es_to_ms_bus    = b;
    data_sram_rdata = rd;
    ws_allow_in     = wa;
    #1;
    exp_v = (sb.size() != 0);
    chk("ms_to_ws_valid", 70'(ms_to_ws_valid), 70'(exp_v));
    chk("ms_allow_in", 70'(ms_allow_in), 70'(!exp_v || wa));
    if (exp_v) begin
      head = sb[0];
      chk("ms_to_ws_bus", ms_to_ws_bus, head);
      chk("ms_to_ds_bus", 70'(ms_to_ds_bus), 70'({1'b1, head[32], head[37:33], head[69:38]}));
      if (wa) void'(sb.pop_front());
    end else begin
      chk("ds_fwd_bits", 70'(ms_to_ds_bus[38:37]), 70'(2'b00));
    end
    if (v && (!exp_v || wa)) sb.push_back(exp_new);
  endtask

  task automatic do_reset();
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    ws_allow_in    = 1'b1;
    reset          = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_valid", 70'(ms_to_ws_valid), 70'(1'b0));
      chk("rst_allow", 70'(ms_allow_in), 70'(1'b1));
      chk("rst_ws_bus", ms_to_ws_bus, 70'(0));
      chk("rst_ds_bus", 70'(ms_to_ds_bus), 70'(0));
      @(negedge clk);
    end
    reset = 1'b1;
    sb.delete();
  endtask

  localparam logic [31:0] RD = 32'h80FF1234;
  logic [4:0]  t_op [10] = '{5'b00010, 5'b00100, 5'b00010, 5'b01000, 5'b10000,
                             5'b01000, 5'b00001, 5'b00000, 5'b01000, 5'b00001};
  logic [1:0]  t_off[10] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd3, 2'd1};
  logic [31:0] t_exp[10] = '{32'hFFFFFF80, 32'h00000080, 32'h00000012, 32'hFFFF80FF,
                             32'h000080FF, 32'h00001234, 32'h80FF1234, 32'h80FF1234,
                             32'hFFFF80FF, 32'h80FF1234};

  initial begin
    logic [77:0] b, b2;
    logic [31:0] rd;
    n_eval = 0;
    n_fail = 0;
    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_rdata = '0;
    ws_allow_in = 1'b1;
    do_reset();

    // Load extraction table, back to back with live rdata.
    rd = 32'h0;
    for (int i = 0; i < 10; i++) begin
      b = mk_bus(32'h1000 + 32'(4*i), 1'b1, 1'b1, 5'(i + 1), 32'h5555AAAA, t_off[i], t_op[i]);
      cyc(1'b1, b, rd, 1'b1, {t_exp[i], 5'(i + 1), 1'b1, 32'h1000 + 32'(4*i)});
      rd = RD;
    end
    cyc(1'b0, '0, RD, 1'b1, '0);

    // Stall: word captured in the first stalled cycle, held while rdata changes.
    b = mk_bus(32'h2000, 1'b1, 1'b1, 5'd9, 32'h0, 2'd0, 5'b00001);
    cyc(1'b1, b, 32'h0, 1'b1, {32'hCAFEF00D, 5'd9, 1'b1, 32'h2000});
    b2 = mk_bus(32'h2004, 1'b1, 1'b0, 5'd10, 32'h77, 2'd0, 5'b0);
    cyc(1'b1, b2, 32'hCAFEF00D, 1'b0, exp_ws(b2, 32'h0));
    for (int i = 0; i < 3; i++) cyc(1'b1, b2, 32'hDEADBEEF, 1'b0, exp_ws(b2, 32'h0));
    // Release and enter together; next load stalls with a byte extract from the buffer.
    b = mk_bus(32'h2008, 1'b1, 1'b1, 5'd11, 32'h0, 2'd3, 5'b00010);
    cyc(1'b1, b, 32'hDEADBEEF, 1'b1, exp_ws(b, 32'h80123456));
    cyc(1'b0, '0, 32'h80123456, 1'b0, '0);
    cyc(1'b0, '0, 32'h00000000, 1'b0, '0);
    cyc(1'b0, '0, 32'h00000000, 1'b1, '0);

    // Back-to-back ALU results with forwarding info.
    for (int i = 1; i <= 3; i++) begin
      b = mk_bus(32'h3000 + 32'(i), 1'(i != 2), 1'b0, 5'(i + 4), 32'(i), 2'd0, 5'b0);
      cyc(1'b1, b, 32'hFFFFFFFF, 1'b1, exp_ws(b, 32'h0));
    end
    cyc(1'b0, '0, 32'h0, 1'b1, '0);

    // Bubble between loads; second load must use live rdata, not the stale buffer.
    b = mk_bus(32'h4000, 1'b1, 1'b1, 5'd20, 32'h0, 2'd2, 5'b10000);
    cyc(1'b1, b, 32'h0, 1'b1, exp_ws(b, 32'hBEEF0001));
    cyc(1'b0, '0, 32'hBEEF0001, 1'b1, '0);
    b = mk_bus(32'h4008, 1'b1, 1'b1, 5'd21, 32'h0, 2'd0, 5'b00001);
    cyc(1'b1, b, 32'h99999999, 1'b1, exp_ws(b, 32'h13572468));
    cyc(1'b0, '0, 32'h13572468, 1'b1, '0);
    cyc(1'b0, '0, 32'h0, 1'b1, '0);

    // Reset mid-stall drops the held instruction.
    b = mk_bus(32'h5000, 1'b1, 1'b1, 5'd3, 32'h0, 2'd0, 5'b00001);
    cyc(1'b1, b, 32'h0, 1'b1, exp_ws(b, 32'h11112222));
    cyc(1'b0, '0, 32'h11112222, 1'b0, '0);
    cyc(1'b0, '0, 32'h0, 1'b0, '0);
    do_reset();
    cyc(1'b0, '0, 32'h0, 1'b1, '0);
    // After reset the capture flag is clear, so a fresh stall captures the new word.
    b = mk_bus(32'h6000, 1'b0, 1'b1, 5'd4, 32'h0, 2'd1, 5'b00100);
    cyc(1'b1, b, 32'h0, 1'b1, exp_ws(b, 32'h0BADF00D));
    cyc(1'b0, '0, 32'h0BADF00D, 1'b0, '0);
    cyc(1'b0, '0, 32'hFFFFFFFF, 1'b1, '0);
    cyc(1'b0, '0, 32'h0, 1'b1, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule

// File: doc/stage4_mem.md
# stage4_mem

Memory-access pipeline stage, directly downstream of the execute stage and upstream of write-back. It registers the execute-to-memory bus, captures the synchronous data-SRAM read word returned one cycle after the execute stage issued the request, and extracts, aligns and extends load data for the five load types. It holds the captured word across write-back back-pressure, and drives the write-back bus plus a forwarding bus to decode.

## Interface
- ES_TO_MS_W, 78, es_to_ms_bus width: [31:0] pc, [32] gr_we, [33] res_from_mem, [38:34] dest, [70:39] alu/mul/div result, [72:71] byte offset, [77:73] ld_op one-hot {ld_hu, ld_h, ld_bu, ld_b, ld_w}.
- MS_TO_WS_W, 70, ms_to_ws_bus width: [31:0] pc, [32] gr_we, [37:33] dest, [69:38] final result.
- MS_TO_DS_W, 39, ms_to_ds_bus width: {fwd_valid, gr_we, dest[4:0], final_result[31:0]}.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0).
- es_to_ms_valid  in  1  execute stage offers an instruction.
- ms_allow_in  out  1  this stage accepts on the current edge.
- es_to_ms_bus  in  ES_TO_MS_W  instruction fields as above.
- data_sram_rdata  in  32  SRAM read word; valid only in the first cycle the load occupies this stage.
- ws_allow_in  in  1  write-back accepts.
- ms_to_ws_valid  out  1  instruction offered to write-back.
- ms_to_ws_bus  out  MS_TO_WS_W  as above.
- ms_to_ds_bus  out  MS_TO_DS_W  forwarding/hazard info to decode.

## Operation
- State: ms_valid, bus register (ES_TO_MS_W), rdata_buf[31:0], rdata_held.
- ms_ready_go = 1 (no internal multi-cycle work).
- ms_allow_in = !ms_valid || (ms_ready_go && ws_allow_in); ms_to_ws_valid = ms_valid && ms_ready_go.
- On edge with ms_allow_in: ms_valid <= es_to_ms_valid; if es_to_ms_valid, bus register <= es_to_ms_bus and rdata_held <= 0. Bus register is not loaded when es_to_ms_valid=0.
- On edge with ms_valid && !rdata_held && !ms_allow_in: rdata_buf <= data_sram_rdata, rdata_held <= 1.
- Load word lw = rdata_held ? rdata_buf : data_sram_rdata.
- Byte select: lw >> (offset*8) low byte. Halfword select: offset[1] ? lw[31:16] : lw[15:0]; offset[0] ignored.
- ld_b: sign-extend byte; ld_bu: zero-extend byte; ld_h: sign-extend half; ld_hu: zero-extend half; ld_w: lw, offset ignored. res_from_mem=1 with ld_op=0 is treated as ld_w.
- final_result = res_from_mem ? load value : bus result.
- ms_to_ws_bus = {final_result, dest, gr_we, pc}.
- fwd_valid = ms_valid; ms_to_ds_bus gr_we field = gr_we && ms_valid.

## Timing
- Reset (reset=0, asynchronous): ms_valid=0, bus register=0, rdata_buf=0, rdata_held=0. Hence ms_to_ws_valid=0, ms_allow_in=1, ms_to_ws_bus=0, ms_to_ds_bus=0.
- Latency: one cycle; an instruction accepted at edge N is offered to write-back during cycle N..N+1 and leaves at the first edge with ws_allow_in=1.
- Throughput: one instruction per cycle when ws_allow_in=1; rdata_buf unused.
- Stall: the first stalled cycle captures rdata. Outputs stay stable while ws_allow_in=0, whatever data_sram_rdata does.
- Simultaneous leave and enter on one edge: the new instruction loads and rdata_held clears; no capture for the leaving one.
- Bubble (ms_valid=0): no capture; outputs driven from stale register but ms_to_ws_valid=0 and forwarding gr_we=0.
- Reset mid-stall drops the held instruction immediately; no output valid until a new accept.
- All outputs are combinational from registers and data_sram_rdata/ws_allow_in; no other paths.

## Test plan
- Reset: hold reset=0 two cycles mid-stream -> ms_to_ws_valid=0, ms_allow_in=1, ms_to_ds_bus=0.
- ld_b offset 3, rdata=0x80FF1234 -> final 0xFFFFFF80; ld_bu same -> 0x00000080; ld_b offset 1 -> 0x00000012.
- ld_h offset 2, rdata=0x80FF1234 -> 0xFFFF80FF; ld_hu offset 2 -> 0x000080FF; ld_h offset 0 -> 0x00001234; ld_w -> 0x80FF1234.
- Stall: ld_w accepted with rdata=0xCAFEF00D, then ws_allow_in=0 three cycles while rdata=0xDEADBEEF -> result stays 0xCAFEF00D; releases on ws_allow_in=1.
- Back-to-back: three ALU results 1,2,3 (res_from_mem=0), ws_allow_in=1 -> outputs 1,2,3 on consecutive cycles; ms_to_ds_bus tracks each dest/gr_we.
- Bubble: es_to_ms_valid=0 one cycle between two loads -> ms_to_ws_valid drops one cycle; second load's rdata taken live, not from the buffer.
